secuenciador_filtro: RTL and testbench

Cycle-level sequencer for the shared multiply-accumulate datapath of the 200 Hz low-pass biquad (direct form II). On each ADC sample strobe it steps the constant, state-variable and accumulator-input multiplexers through one fixed 6-step MAC program. It pulses the accumulator enable and the shift-register load, then flags completion to the output register. It replaces the free-running mux controller. It adds one-deep buffering of sample strobes and overrun reporting, so back-to-back ADC strobes are never silently merged.

---
 rtl/filtro_pkg.sv | 101 ++++++++++
 rtl/secuenciador_filtro_detector_flanco.sv | 26 ++
 rtl/secuenciador_filtro.sv | 87 ++++++++
 tb/tb_secuenciador_filtro.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared definitions for the biquad MAC sequencer: states, selector codes and
// the per-state output decode of the fixed 6-step program.
package filtro_pkg;

    localparam int CICLOS_PROG = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A1    = 3'd1,
        ST_A2    = 3'd2,
        ST_SHIFT = 3'd3,
        ST_B0    = 3'd4,
        ST_B1    = 3'd5,
        ST_B2    = 3'd6,
        ST_DONE  = 3'd7
    } estado_t;

    localparam logic [2:0] CONST_A1   = 3'd0;
    localparam logic [2:0] CONST_A2   = 3'd1;
    localparam logic [2:0] CONST_B0   = 3'd2;
    localparam logic [2:0] CONST_B1   = 3'd3;
    localparam logic [2:0] CONST_B2   = 3'd4;
    localparam logic [2:0] CONST_CERO = 3'd5;

    localparam logic [1:0] FUN_FK   = 2'd0;
    localparam logic [1:0] FUN_FK_1 = 2'd1;
    localparam logic [1:0] FUN_FK_2 = 2'd2;

    localparam logic [1:0] ACUM_UK   = 2'd0;
    localparam logic [1:0] ACUM_REG  = 2'd1;
    localparam logic [1:0] ACUM_CERO = 2'd2;

    typedef struct packed {
        logic [2:0] sel_const;
        logic [1:0] sel_fun;
        logic [1:0] sel_acum;
        logic       acum_en;
        logic       shift;
        logic       band_listo;
        logic       busy;
    } salidas_t;

    localparam salidas_t SALIDAS_REPOSO = '{
        sel_const:  CONST_CERO,
        sel_fun:    FUN_FK,
        sel_acum:   ACUM_CERO,
        acum_en:    1'b0,
        shift:      1'b0,
        band_listo: 1'b0,
        busy:       1'b0
    };

    // Moore decode: the feedback half (A1, A2) builds f[k], SHIFT stores it,
    // the feed-forward half (B0..B2) builds y[k] from the shifted states.
    function automatic salidas_t decodificar(input estado_t e);
        salidas_t s;
        s      = SALIDAS_REPOSO;
        s.busy = (e != ST_IDLE);
        case (e)
            ST_A1: begin
                s.sel_acum  = ACUM_UK;
                s.sel_fun   = FUN_FK;
                s.sel_const = CONST_A1;
                s.acum_en   = 1'b1;
            end
            ST_A2: begin
                s.sel_acum  = ACUM_REG;
                s.sel_fun   = FUN_FK_1;
                s.sel_const = CONST_A2;
                s.acum_en   = 1'b1;
            end
            ST_SHIFT: begin
                s.sel_acum  = ACUM_REG;
                s.sel_const = CONST_CERO;
                s.shift     = 1'b1;
            end
            ST_B0: begin
                s.sel_acum  = ACUM_CERO;
                s.sel_fun   = FUN_FK;
                s.sel_const = CONST_B0;
                s.acum_en   = 1'b1;
            end
            ST_B1: begin
                s.sel_acum  = ACUM_REG;
                s.sel_fun   = FUN_FK_1;
                s.sel_const = CONST_B1;
                s.acum_en   = 1'b1;
            end
            ST_B2: begin
                s.sel_acum  = ACUM_REG;
                s.sel_fun   = FUN_FK_2;
                s.sel_const = CONST_B2;
                s.acum_en   = 1'b1;
            end
            ST_DONE: s.band_listo = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/secuenciador_filtro_detector_flanco.sv
// Registered rising-edge detector for the ADC sample strobe.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic bandera,
    output logic flanco
);

    logic bandera_d;
    logic bandera_q;

    always_comb begin
        bandera_d = bandera;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bandera_q <= 1'b0;
        end else begin
            bandera_q <= bandera_d;
        end
    end

    assign flanco = bandera & ~bandera_q;

endmodule

// File: rtl/secuenciador_filtro.sv
// Sequencer for the shared MAC datapath of the 200 Hz biquad: one 6-step
// program per ADC strobe, with a one-deep strobe buffer and sticky overrun.
module secuenciador_filtro
    import filtro_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Bandera_ADC,
    input  logic       clr_overrun,
    output logic [2:0] sel_const,
    output logic [1:0] sel_fun,
    output logic [1:0] sel_acum,
    output logic       acum_en,
    output logic       shift,
    output logic       Band_Listo,
    output logic       busy,
    output logic       overrun
);

    logic     flanco;
    estado_t  estado_d, estado_q;
    logic     pending_d, pending_q;
    logic     overrun_d, overrun_q;
    logic     overrun_set;
    salidas_t salidas_d, salidas_q;

    detector_flanco u_detector_flanco (
        .clk     (clk),
        .reset   (reset),
        .bandera (Bandera_ADC),
        .flanco  (flanco)
    );

    always_comb begin
        estado_d    = estado_q;
        pending_d   = pending_q;
        overrun_set = 1'b0;
        case (estado_q)
            // A buffered strobe and a fresh one together: start on the buffered
            // one and keep the fresh one waiting.
            ST_IDLE, ST_DONE: begin
                estado_d  = (flanco | pending_q) ? ST_A1 : ST_IDLE;
                pending_d = pending_q & flanco;
            end
            ST_A1:    estado_d = ST_A2;
            ST_A2:    estado_d = ST_SHIFT;
            ST_SHIFT: estado_d = ST_B0;
            ST_B0:    estado_d = ST_B1;
            ST_B1:    estado_d = ST_B2;
            ST_B2:    estado_d = ST_DONE;
            default:  estado_d = ST_IDLE;
        endcase

        if (estado_q != ST_IDLE && estado_q != ST_DONE) begin
            pending_d   = pending_q | flanco;
            overrun_set = pending_q & flanco;
        end

        overrun_d = overrun_set | (overrun_q & ~clr_overrun);
        salidas_d = decodificar(estado_d);
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= ST_IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            salidas_q <= SALIDAS_REPOSO;
        end else begin
            estado_q  <= estado_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            salidas_q <= salidas_d;
        end
    end

    assign sel_const  = salidas_q.sel_const;
    assign sel_fun    = salidas_q.sel_fun;
    assign sel_acum   = salidas_q.sel_acum;
    assign acum_en    = salidas_q.acum_en;
    assign shift      = salidas_q.shift;
    assign Band_Listo = salidas_q.band_listo;
    assign busy       = salidas_q.busy;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Scoreboard bench for secuenciador_filtro: stimulus queues the expected
// per-cycle program outputs, a negedge monitor pops and compares them.
module tb_secuenciador_filtro;

    logic       clk = 1'b0;
    logic       reset;
    logic       Bandera_ADC;
    logic       clr_overrun;
    logic [2:0] sel_const;
    logic [1:0] sel_fun;
    logic [1:0] sel_acum;
    logic       acum_en;
    logic       shift;
    logic       Band_Listo;
    logic       busy;
    logic       overrun;

    secuenciador_filtro dut (
        .clk         (clk),
        .reset       (reset),
        .Bandera_ADC (Bandera_ADC),
        .clr_overrun (clr_overrun),
        .sel_const   (sel_const),
        .sel_fun     (sel_fun),
        .sel_acum    (sel_acum),
        .acum_en     (acum_en),
        .shift       (shift),
        .Band_Listo  (Band_Listo),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [10:0] vec;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en       = 1'b0;
    bit end_req      = 1'b0;
    bit end_chk      = 1'b0;
    bit exp_ovr_idle = 1'b0;

    localparam int NO_OV = 32'h4000_0000;

    // {sel_const, sel_fun, sel_acum, acum_en, shift, Band_Listo} for A1..DONE
    localparam logic [9:0] PROG [0:6] = '{
        {3'd0, 2'd0, 2'd0, 3'b100},
        {3'd1, 2'd1, 2'd1, 3'b100},
        {3'd5, 2'd0, 2'd1, 3'b010},
        {3'd2, 2'd0, 2'd2, 3'b100},
        {3'd3, 2'd1, 2'd1, 3'b100},
        {3'd4, 2'd2, 2'd1, 3'b100},
        {3'd5, 2'd0, 2'd2, 3'b001}
    };

    task automatic push_steps(input int start, input int n, input int ov_from);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = start + i;
            e.vec = {PROG[i], ((start + i) >= ov_from) ? 1'b1 : 1'b0};
            sb_q.push_back(e);
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_scenario(output int b);
        reset        = 1'b1;
        Bandera_ADC  = 1'b0;
        clr_overrun  = 1'b0;
        exp_ovr_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        b     = cyc;
    endtask

    task automatic apply_stimulus(input int c, input int len);
        go_to(c);
        Bandera_ADC = 1'b1;
        go_to(c + len);
        Bandera_ADC = 1'b0;
    endtask

    // Busy cycles must match the queued program; idle cycles must show defaults.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_busy: got busy=1 at cycle %0d, required busy=0", cyc);
                end else begin
                    e_mon = sb_q.pop_front();
                    n_checks += 2;
                    if (e_mon.cyc != cyc) begin
                        n_fail++;
                        $display("[TB] FAIL program_cycle: got step at cycle %0d, required cycle %0d", cyc, e_mon.cyc);
                    end
                    if ({sel_const, sel_fun, sel_acum, acum_en, shift, Band_Listo, overrun} !== e_mon.vec) begin
                        n_fail++;
                        $display("[TB] FAIL step_outputs: cycle %0d got %b required %b", cyc,
                                 {sel_const, sel_fun, sel_acum, acum_en, shift, Band_Listo, overrun}, e_mon.vec);
                    end
                end
            end else begin
                n_checks += 2;
                if ({sel_const, sel_fun, sel_acum, acum_en, shift, Band_Listo, busy} !== {3'd5, 2'd0, 2'd2, 4'b0000}) begin
                    n_fail++;
                    $display("[TB] FAIL idle_outputs: cycle %0d got %b required %b", cyc,
                             {sel_const, sel_fun, sel_acum, acum_en, shift, Band_Listo, busy}, {3'd5, 2'd0, 2'd2, 4'b0000});
                end
                if (overrun !== exp_ovr_idle) begin
                    n_fail++;
                    $display("[TB] FAIL idle_overrun: cycle %0d got %b required %b", cyc, overrun, exp_ovr_idle);
                end
            end
            if (end_req && !end_chk) begin
                n_checks++;
                if (sb_q.size() != 0) begin
                    n_fail++;
                    $display("[TB] FAIL missing_steps: got %0d steps never seen, required 0", sb_q.size());
                end
                end_chk = 1'b1;
            end
        end
    end

    initial begin
        int b;
        reset       = 1'b1;
        Bandera_ADC = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        $display("[TB] idle after reset");
        start_scenario(b);
        go_to(b + 20);

        $display("[TB] single strobe held high");
        start_scenario(b);
        push_steps(b + 11, 7, NO_OV);
        apply_stimulus(b + 10, 15);
        go_to(b + 30);

        $display("[TB] strobe while busy is buffered");
        start_scenario(b);
        push_steps(b + 11, 7, NO_OV);
        push_steps(b + 18, 7, NO_OV);
        apply_stimulus(b + 10, 1);
        apply_stimulus(b + 14, 1);
        go_to(b + 32);

        $display("[TB] third strobe overruns, then clear");
        start_scenario(b);
        push_steps(b + 11, 7, b + 15);
        push_steps(b + 18, 7, b + 15);
        apply_stimulus(b + 10, 1);
        apply_stimulus(b + 12, 1);
        apply_stimulus(b + 14, 1);
        go_to(b + 20);
        exp_ovr_idle = 1'b1;
        go_to(b + 30);
        clr_overrun = 1'b1;
        go_to(b + 31);
        clr_overrun  = 1'b0;
        exp_ovr_idle = 1'b0;
        go_to(b + 35);

        $display("[TB] strobe on the DONE cycle");
        start_scenario(b);
        push_steps(b + 11, 7, NO_OV);
        push_steps(b + 18, 7, NO_OV);
        apply_stimulus(b + 10, 1);
        apply_stimulus(b + 17, 1);
        go_to(b + 30);

        $display("[TB] reset during SHIFT drops sample and buffer");
        start_scenario(b);
        push_steps(b + 11, 2, NO_OV);
        apply_stimulus(b + 10, 1);
        apply_stimulus(b + 12, 1);
        go_to(b + 13);
        reset = 1'b1;
        go_to(b + 16);
        reset = 1'b0;
        push_steps(b + 21, 7, NO_OV);
        apply_stimulus(b + 20, 1);
        go_to(b + 35);

        end_req = 1'b1;
        go_to(cyc + 3);
        if (!end_chk) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL end_check: got no final check, required one");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
